// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the synchronous FIFO slice.
//               - clog2 : constant ceil(log2(value)); clog2(1) = 0
//               - FIFO_DATA_W / FIFO_DEPTH : default geometry (16 x 16)
// Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_DEPTH  = 16;

  // Elaboration-time ceil(log2(value)).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port storage array, DATA_W x DEPTH.
//               Synchronous write port, registered read port.
//               The array and the read register carry no reset.
// Ports       : clk            - clock, rising edge
//               we/waddr/wdata - write enable, address, data
//               re/raddr       - read enable, address
//               rdata          - registered read data, holds while re=0
// Revision    : 1.0  initial release
// ============================================================================
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule : fifo_ram
`default_nettype wire

// File: rtl/sync_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_buffer
// Description : Parametrised single-clock FIFO with occupancy count,
//               full/empty and almost-full/almost-empty flags, one-cycle
//               read latency with rd_valid strobe, and sticky
//               overflow/underflow error flags.
// Ports       : clk, rst     - clock / synchronous active-high reset
//               w, data_in   - write request and data
//               r            - read request
//               clr_err      - clears overflow/underflow
//               data_out     - registered read data
//               rd_valid     - pulse: data_out updated this cycle
//               full, empty, almost_full, almost_empty, count - status
//               overflow     - sticky: a write was rejected
//               underflow    - sticky: a read was rejected
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        r,
  input  logic                        clr_err,
  output logic [DATA_W-1:0]           data_out,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF_LEVEL  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE_LEVEL  = CNT_W'(AE_LEVEL);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;
  // Set by the first accepted read after reset; until then data_out reads
  // as zero because the RAM read register itself is not reset.
  logic              r_dout_live;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_full  = (r_count == C_DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // A read on a full FIFO frees a slot in the same cycle, so the write
  // may proceed. An empty FIFO never bypasses write data to the reader.
  assign w_rd_acc = r & ~w_empty;
  assign w_wr_acc = w & (~w_full | r);

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_acc & ~rst),
    .waddr (r_wptr),
    .wdata (data_in),
    .re    (w_rd_acc & ~rst),
    .raddr (r_rptr),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dout_live <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_rptr      <= r_rptr + ADDR_W'(1);
        r_dout_live <= 1'b1;
      end
      r_rd_valid <= w_rd_acc;

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // A new error event takes precedence over a coincident clear.
      if (w & w_full & ~r) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end

      if (r & w_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign data_out     = r_dout_live ? w_ram_rdata : '0;
  assign rd_valid     = r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF_LEVEL);
  assign almost_empty = (r_count <= C_AE_LEVEL);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule : sync_fifo_buffer
`default_nettype wire

// File: tb/tb_sync_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_buffer
// Description : Directed self-checking bench for sync_fifo_buffer with
//               DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, DATA_W=16.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_buffer;

  logic        clk;
  logic        rst;
  logic        w;
  logic [15:0] data_in;
  logic        r;
  logic        clr_err;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_pass   = 0;

  sync_fifo_buffer #(
    .DATA_W   (16),
    .DEPTH    (4),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w            (w),
    .data_in      (data_in),
    .r            (r),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic iw, input logic ir, input logic [15:0] d, input logic iclr);
    w       = iw;
    r       = ir;
    data_in = d;
    clr_err = iclr;
    @(posedge clk);
    #1;
    w       = 1'b0;
    r       = 1'b0;
    clr_err = 1'b0;
  endtask

  // Expected flag vector {full, empty, almost_full, almost_empty} for DEPTH=4, AF=3, AE=1.
  function automatic logic [3:0] exp_flags(input int c);
    return {c == 4, c == 0, c >= 3, c <= 1};
  endfunction

  task automatic check_level(input string tag, input int c);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_flags"}, {28'd0, full, empty, almost_full, almost_empty}, {28'd0, exp_flags(c)});
  endtask

  task automatic wr(input string tag, input logic [15:0] d, input int c_after);
    cyc(1'b1, 1'b0, d, 1'b0);
    check_level(tag, c_after);
  endtask

  task automatic rd(input string tag, input logic [15:0] d_exp, input int c_after);
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    check({tag, "_rdv"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(d_exp));
    check_level(tag, c_after);
  endtask

  initial begin
    rst = 1'b1; w = 1'b0; r = 1'b0; clr_err = 1'b0; data_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);

    // Reset state
    check_level("rst", 0);
    check("rst_rdv",  32'(rd_valid),  32'd0);
    check("rst_data", 32'(data_out),  32'd0);
    check("rst_ovf",  32'(overflow),  32'd0);
    check("rst_unf",  32'(underflow), 32'd0);

    // Fill then drain
    wr("fill1", 16'h0011, 1);
    wr("fill2", 16'h0022, 2);
    wr("fill3", 16'h0033, 3);
    wr("fill4", 16'h0044, 4);
    rd("drain1", 16'h0011, 3);
    rd("drain2", 16'h0022, 2);
    rd("drain3", 16'h0033, 1);
    rd("drain4", 16'h0044, 0);
    cyc(1'b0, 1'b0, 16'hFFFF, 1'b0);
    check("idle_rdv",  32'(rd_valid), 32'd0);
    check("idle_hold", 32'(data_out), 32'h0044);

    // Wrap-around
    for (int i = 0; i < 4; i++) wr("wrapf", 16'(16'hA0 + i), i + 1);
    rd("wrap_a0", 16'h00A0, 3);
    rd("wrap_a1", 16'h00A1, 2);
    wr("wrap_b0", 16'h00B0, 3);
    wr("wrap_b1", 16'h00B1, 4);
    rd("wrap_a2", 16'h00A2, 3);
    rd("wrap_a3", 16'h00A3, 2);
    rd("wrap_rb0", 16'h00B0, 1);
    rd("wrap_rb1", 16'h00B1, 0);

    // Simultaneous read/write while full
    for (int i = 0; i < 4; i++) wr("simf", 16'(i + 1), i + 1);
    cyc(1'b1, 1'b1, 16'h5555, 1'b0);
    check("sim_rdv",  32'(rd_valid), 32'd1);
    check("sim_data", 32'(data_out), 32'h0001);
    check_level("sim", 4);
    check("sim_ovf",  32'(overflow), 32'd0);
    rd("sim_r2", 16'h0002, 3);
    rd("sim_r3", 16'h0003, 2);
    rd("sim_r4", 16'h0004, 1);
    rd("sim_r5", 16'h5555, 0);

    // Overflow
    for (int i = 0; i < 4; i++) wr("ovff", 16'(16'h61 + i), i + 1);
    cyc(1'b1, 1'b0, 16'hDEAD, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check_level("ovf", 4);
    rd("ovf_r1", 16'h0061, 3);
    rd("ovf_r2", 16'h0062, 2);
    rd("ovf_r3", 16'h0063, 1);
    rd("ovf_r4", 16'h0064, 0);

    // Underflow: rejected read leaves data_out alone
    cyc(1'b0, 1'b1, 16'h0000, 1'b0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_rdv",  32'(rd_valid),  32'd0);
    check("unf_data", 32'(data_out),  32'h0064);
    check("unf_ovf",  32'(overflow),  32'd1);
    check_level("unf", 0);

    // Clear coinciding with a new underflow: set wins
    cyc(1'b0, 1'b1, 16'h0000, 1'b1);
    check("clrset_unf", 32'(underflow), 32'd1);
    check("clrset_ovf", 32'(overflow),  32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    check("clr_unf", 32'(underflow), 32'd0);
    check("clr_ovf", 32'(overflow),  32'd0);

    // Empty with w and r together: write only, read rejected
    cyc(1'b1, 1'b1, 16'h0099, 1'b0);
    check("ewr_rdv", 32'(rd_valid),  32'd0);
    check("ewr_unf", 32'(underflow), 32'd1);
    check_level("ewr", 1);
    rd("ewr_rd", 16'h0099, 0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    check("ewr_clr", 32'(underflow), 32'd0);

    // Reset mid-stream with w and r asserted
    wr("mid1", 16'h0071, 1);
    wr("mid2", 16'h0072, 2);
    wr("mid3", 16'h0073, 3);
    rst = 1'b1; w = 1'b1; r = 1'b1; data_in = 16'h0BAD;
    @(posedge clk);
    #1;
    rst = 1'b0; w = 1'b0; r = 1'b0;
    check_level("midrst", 0);
    check("midrst_rdv",  32'(rd_valid), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    wr("post_w", 16'h0777, 1);
    rd("post_r", 16'h0777, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sync_fifo_buffer
`default_nettype wire
